// File: rtl/booth_pp_accumulator.sv
// Accumulates four radix-4 Booth partial products into a 16-bit signed 8x8 product.
// Uses one adder, one partial product per cycle, and valid/ready handshakes on both sides.
module booth_pp_accumulator (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  PP0,
  input  logic [8:0]  PP1,
  input  logic [8:0]  PP2,
  input  logic [8:0]  PP3,
  input  logic        Sign0,
  input  logic        Sign1,
  input  logic        Sign2,
  input  logic        Sign3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0][8:0] pp_q;
  logic [3:0]      sign_q;
  logic [15:0]     acc;
  logic [1:0]      step;
  logic [15:0]     ext;
  logic [15:0]     ext_shifted;
  logic            accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;
  assign accept    = in_valid && in_ready;

  // Bits 15:9 come from the separate sign bit, so PP=9'h100 with Sign=0 is +256.
  assign ext         = {{7{sign_q[step]}}, pp_q[step]};
  assign ext_shifted = ext << {step, 1'b0};

  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (in_valid)      state_next = ACC;
      ACC:     if (step == 2'd3)  state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      step   <= '0;
      // NOTE: the operand registers are cleared too, so nothing captured survives an abort.
      pp_q   <= '0;
      sign_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        pp_q   <= {PP3, PP2, PP1, PP0};
        sign_q <= {Sign3, Sign2, Sign1, Sign0};
        acc    <= '0;
        step   <= '0;
      end else if (state == ACC) begin
        acc  <= acc + ext_shifted;
        step <= step + 2'd1;
      end
    end
  end

endmodule
